pwm_multi_chan: RTL and testbench
=================================

// Module: pwm_multi_chan
// PURPOSE
//  N-channel PWM generator sharing one programmable-period counter. Per-channel duty
//  writes land in shadow registers, promoted to active only at period boundary
//  (glitch-free updates). Drives motor/LED/servo outputs; host-side regs write duty/period.
// PARAMETERS
//  WIDTH     10  counter, period and duty width in bits
//  CHANNELS   4  number of PWM outputs (>=1)
//  CH_W       $clog2(CHANNELS) (min 1)  channel-select width, derived, not overridden
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst         in   1         asynchronous reset, active-high
//  en          in   1         1 = run; 0 = counter parked at 0, outputs low
//  period      in   WIDTH     terminal count P; sampled only at reload
//  duty_wr     in   1         write strobe for duty shadow register
//  duty_ch     in   CH_W      channel selected by duty_wr
//  duty_in     in   WIDTH     duty value written to shadow[duty_ch]
//  pwm_out     out  CHANNELS  registered PWM outputs
//  period_start out 1         one-cycle pulse, first output cycle of each period
// BEHAVIOUR
//  - Reset: cnt=0, period_q=0, shadow[*]=0, active[*]=0, pwm_out=0, period_start=0.
//  - Write: duty_wr=1 -> shadow[duty_ch]<=duty_in next edge; duty_ch>=CHANNELS ignored.
//    Accepted regardless of en.
//  - Edge-aligned counting (en=1): cnt 0,1..period_q, then 0; period = period_q+1 cycles.
//  - Reload: on edge where cnt wraps to 0: active[*]<=shadow[*], period_q<=period.
//    Write in the same cycle as reload: reload takes pre-edge shadow; new value
//    applies from the following period.
//  - Output: pwm_out[i] <= en & (cnt < active[i]); one-cycle latency from cnt.
//    High time per period = min(active[i], period_q+1): duty 0 -> constant low,
//    duty > period_q -> constant high (no single-cycle glitch at wrap).
//  - period_start <= en & (cnt==0); aligned with pwm_out for cnt=0.
//  - period_q=0: one-cycle period, reload every cycle.
//  - en=0: cnt held 0, reload every cycle (active/period_q track shadow/period),
//    pwm_out=0 next edge. en rising: first period uses latest shadow/period.
//  - Reset mid-period: all state cleared immediately (async), outputs low.
//  - Writing period smaller than current cnt has no effect until reload.
// CONFIGURATION
//  PWM_CENTER_ALIGN_EN defined: up/down counter. cnt 0..period_q then period_q-1..1,
//    then 0; period = 2*period_q cycles (period_q=0: cnt held 0, 1-cycle period).
//    Reload on edge where cnt becomes 0. Output rule unchanged (cnt < active[i]);
//    high time = 0 for duty 0, 2*duty-1 for 1<=duty<=period_q, full period otherwise.
//    Pulses symmetric about cnt=0.
//  Undefined: edge-aligned only, no direction flop.
// STRUCTURE
//  pwm_pkg: PWM_WIDTH_DEF=10, PWM_CHANNELS_DEF=4, counter direction constants
//    (CNT_UP/CNT_DOWN) used under PWM_CENTER_ALIGN_EN.
//  Sub-module pwm_chan_cmp: per-channel shadow+active register, comparator, output
//    flop; inputs cnt, reload, en, write enable, duty_in. Instantiated via generate.
//  Top owns counter, direction, period_q, reload and period_start logic.
// TESTING
//  1 Reset then P=9, ch0 duty=3, en=1 -> pwm_out[0] 3 high/7 low repeating;
//    period_start every 10 cycles.
//  2 Duty 0 and duty 15 (P=9) on ch1/ch2 -> ch1 constant 0, ch2 constant 1,
//    no glitch at wrap over 5 periods.
//  3 Write ch0 duty 3->6 mid-period -> current period still 3 high; next 6 high.
//    Write coincident with reload edge -> applies one period later.
//  4 Change P 9->4 mid-period -> current period 10 cycles, then 5-cycle periods.
//  5 Drop en mid-period, write ch3=2, raise en -> outputs low while en=0;
//    first period restarts at cnt=0 with ch3=2. Assert rst mid-high -> pwm_out 0 at once.
//  6 PWM_CENTER_ALIGN_EN, P=8, duty=3 -> 16-cycle period, 5 high cycles centered
//    on cnt=0; duty=9 -> constant high.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and counter-direction encoding for the PWM block.
// Direction constants are only consumed when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF    = 10;
    localparam int PWM_CHANNELS_DEF = 4;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    // Channel-select width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_chan_cmp.sv
// pwm_chan_cmp: one PWM channel - duty shadow, active duty, compare, output flop.
// Shadow takes host writes any time; active only changes on the reload strobe.
module pwm_chan_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_reload,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_duty,
    output logic             o_pwm
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;
    logic             w_hit;

    // Host write into the shadow duty register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (i_wr) begin
            r_shadow <= i_duty;
        end
    end

    // Promote shadow to active only at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= '0;
        end else if (i_reload) begin
            r_active <= r_shadow;
        end
    end

    assign w_hit = (i_cnt < r_active);

    // Registered output, forced low while the block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= i_en & w_hit;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_chan.sv
// pwm_multi_chan: N-channel PWM sharing one programmable-period counter.
// Define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) counter.
module pwm_multi_chan
    import pwm_pkg::*;
#(
    parameter  int WIDTH    = PWM_WIDTH_DEF,
    parameter  int CHANNELS = PWM_CHANNELS_DEF,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    period,
    input  logic                duty_wr,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [WIDTH-1:0]    duty_in,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_period_q;
    logic                r_period_start;
    logic [WIDTH-1:0]    w_cnt_nxt;
    logic                w_reload;
    logic [CHANNELS-1:0] w_wr;

`ifdef PWM_CENTER_ALIGN_EN

    cnt_dir_e r_dir;
    cnt_dir_e w_dir_nxt;

    // Triangle count 0..P..1; disabled or P=0 parks the counter at 0.
    always_comb begin
        w_cnt_nxt = '0;
        w_dir_nxt = CNT_UP;
        if (en && (r_period_q != '0)) begin
            if ((r_dir == CNT_UP) && (r_cnt < r_period_q)) begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_dir_nxt = CNT_UP;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
                w_dir_nxt = (r_cnt == WIDTH'(1)) ? CNT_UP : CNT_DOWN;
            end
        end
    end

    // Direction flop for the up/down counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= CNT_UP;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end

`else

    // Sawtooth count 0..P then wrap; disabled parks the counter at 0.
    always_comb begin
        w_cnt_nxt = '0;
        if (en && (r_cnt < r_period_q)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

`endif

    // Every edge that lands the counter on 0 starts a new period.
    assign w_reload = (w_cnt_nxt == '0);

    // Counter, latched period and period-start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_period_q     <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_period_start <= en & (r_cnt == '0);
            if (w_reload) begin
                r_period_q <= period;
            end
        end
    end

    assign period_start = r_period_start;

    // Decode the write strobe; out-of-range channels match nothing.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr && (duty_ch == CH_W'(i))) begin
                w_wr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_chan_cmp #(
            .WIDTH (WIDTH)
        ) u_cmp (
            .clk      (clk),
            .rst      (rst),
            .i_en     (en),
            .i_reload (w_reload),
            .i_wr     (w_wr[g]),
            .i_cnt    (r_cnt),
            .i_duty   (duty_in),
            .o_pwm    (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_chan.sv
// tb_pwm_multi_chan: directed stimulus with a per-cycle expectation queue.
// A monitor pops one expected {pwm_out, period_start} after every clock edge.
module tb_pwm_multi_chan;

    localparam int W = 10;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] period = '0;
    logic         duty_wr = 1'b0;
    logic [1:0]   duty_ch = '0;
    logic [W-1:0] duty_in = '0;
    logic [N-1:0] pwm_out;
    logic         period_start;

    typedef struct {
        logic [N-1:0] pwm;
        logic         ps;
        int           k;
    } exp_t;

    exp_t         q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           k = 0;
    logic         s_en = 1'b0;
    logic [W-1:0] s_per = '0;

    always #5 clk = ~clk;

    pwm_multi_chan #(
        .WIDTH    (W),
        .CHANNELS (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period       (period),
        .duty_wr      (duty_wr),
        .duty_ch      (duty_ch),
        .duty_in      (duty_in),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string nm, input int idx,
                         input logic [N-1:0] ap, input logic [N-1:0] ep,
                         input logic aps, input logic eps);
        n_chk++;
        if (ap !== ep || aps !== eps) begin
            n_fail++;
            $display("FAIL %s k=%0d pwm_out=%b period_start=%b required pwm_out=%b period_start=%b",
                     nm, idx, ap, aps, ep, eps);
        end
    endtask

    // Expected outputs when every channel compares phase against its duty.
    function automatic logic [N-1:0] pat(input int ph, input int d0,
                                         input int d1, input int d2,
                                         input int d3);
        return {ph < d3, ph < d2, ph < d1, ph < d0};
    endfunction

    // Drive one cycle of inputs and queue the output seen after the next edge.
    task automatic cyc(input logic wr, input logic [1:0] ch,
                       input logic [W-1:0] d, input logic [N-1:0] ep,
                       input logic eps);
        exp_t e;
        @(negedge clk);
        en      = s_en;
        period  = s_per;
        duty_wr = wr;
        duty_ch = ch;
        duty_in = d;
        e.pwm   = ep;
        e.ps    = eps;
        e.k     = k;
        q.push_back(e);
        k++;
    endtask

    task automatic idle(input logic [N-1:0] ep, input logic eps);
        cyc(1'b0, 2'd0, '0, ep, eps);
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("cycle", e.k, pwm_out, e.pwm, period_start, e.ps);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ph;
        int d0;
        int d2;
        // Reset held: everything low.
        idle('0, 1'b0);
        idle('0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
        s_per = 10'd8;
        cyc(1'b1, 2'd0, 10'd3, '0, 1'b0);
        cyc(1'b1, 2'd1, 10'd9, '0, 1'b0);
        idle('0, 1'b0);
        idle('0, 1'b0);
        s_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            ph = i % 16;
            ph = (ph <= 8) ? ph : 16 - ph;
            idle(pat(ph, 3, 9, 0, 0), ph == 0);
        end
        s_en = 1'b0;
        idle('0, 1'b0);
`else
        // Test 1: P=9, ch0 duty 3 -> 3 high / 7 low.
        s_per = 10'd9;
        cyc(1'b1, 2'd0, 10'd3, '0, 1'b0);
        idle('0, 1'b0);
        idle('0, 1'b0);
        s_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            idle(pat(i % 10, 3, 0, 0, 0), (i % 10) == 0);
        end
        // Test 2: ch1 duty 0, ch2 duty 15 -> constant low / high.
        for (int i = 30; i < 90; i++) begin
            d2 = (i >= 40) ? 15 : 0;
            cyc(i == 30 || i == 31, (i == 30) ? 2'd1 : 2'd2,
                (i == 30) ? 10'd0 : 10'd15,
                pat(i % 10, 3, 0, d2, 0), (i % 10) == 0);
        end
        // Test 3: mid-period write, then a write on the reload edge.
        for (int i = 90; i < 130; i++) begin
            d0 = (i < 100) ? 3 : (i < 120) ? 6 : 2;
            cyc(i == 92 || i == 109, 2'd0,
                (i == 92) ? 10'd6 : 10'd2,
                pat(i % 10, d0, 0, 15, 0), (i % 10) == 0);
        end
        // Test 4: P 9->4 mid-period takes effect after the wrap.
        for (int i = 130; i < 155; i++) begin
            if (i == 133) s_per = 10'd4;
            ph = (i < 140) ? (i % 10) : ((i - 140) % 5);
            idle(pat(ph, 2, 0, 15, 0), ph == 0);
        end
        // Test 5: drop en, write ch3=2, raise en.
        for (int i = 155; i < 172; i++) begin
            s_en = !(i >= 157 && i <= 160);
            if (!s_en) begin
                cyc(i == 158, 2'd3, 10'd2, '0, 1'b0);
            end else if (i < 157) begin
                ph = (i - 140) % 5;
                idle(pat(ph, 2, 0, 15, 0), ph == 0);
            end else begin
                ph = (i - 161) % 5;
                idle(pat(ph, 2, 0, 15, 2), ph == 0);
            end
        end
        // Async reset while outputs are high.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", k, pwm_out, '0, period_start, 1'b0);
        s_en = 1'b0;
        idle('0, 1'b0);
        idle('0, 1'b0);
`endif

        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain left=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
